// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: port A has priority,
// contended grants alternate, and a wait counter force-grants a refused port B.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_dwe,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          b_starved
);

    typedef enum logic {WIN_A = 1'b0, WIN_B = 1'b1} winner_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    winner_t    last_winner;
    logic       contended_seen;
    logic [3:0] wait_cnt;
    logic       both;
    logic       forced;
    logic       pick_b;

    // Alternation only applies once a contended grant has happened since reset,
    // so A takes the very first contended cycle.
    always_comb begin
        both      = a_req & b_req;
        forced    = both & (wait_cnt == MAX_W);
        pick_b    = b_req & (~a_req | forced | (contended_seen & (last_winner == WIN_A)));
        a_gnt     = ~rst & a_req & ~pick_b;
        b_gnt     = ~rst & pick_b;
        mem_dwe   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_dwe   = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_dwe   = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    assign rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid       <= 1'b0;
            b_rvalid       <= 1'b0;
            b_starved      <= 1'b0;
            wait_cnt       <= '0;
            last_winner    <= WIN_A;
            contended_seen <= 1'b0;
        end else begin
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            if (both) begin
                last_winner    <= pick_b ? WIN_B : WIN_A;
                contended_seen <= 1'b1;
            end
            if (forced) begin
                b_starved <= 1'b1;
            end
            if (!b_req || b_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != MAX_W) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x16 registered-read memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, b_starved;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic        mem_dwe;
    logic [7:0]  mem_addr;

    logic        s_a_gnt, s_a_rvalid, s_b_gnt, s_b_rvalid, s_dwe, s_b_starved;
    logic [15:0] s_rdata, s_wdata;
    logic [7:0]  s_addr;

    logic [15:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(16), .MAX_WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata), .mem_dwe(mem_dwe), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .b_starved(b_starved)
    );

    // Same stimulus with MAX_WAIT=1 so the forced-grant path is reachable.
    dmem_arbiter #(.AW(8), .DW(16), .MAX_WAIT(1)) dut_s (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(s_a_gnt), .a_rvalid(s_a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(s_b_gnt), .b_rvalid(s_b_rvalid),
        .rdata(s_rdata), .mem_dwe(s_dwe), .mem_addr(s_addr),
        .mem_wdata(s_wdata), .mem_rdata(16'h0000), .b_starved(s_b_starved)
    );

    always @(posedge clk) begin
        if (mem_dwe) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    endtask

    initial begin
        logic prev_a, prev_b;
        rst = 1;
        idle();
        next_cycle();
        a_req = 1; a_we = 1; a_addr = 8'h44; a_wdata = 16'h5555;
        #2;
        check("rst_a_gnt", a_gnt, 0);
        check("rst_dwe", mem_dwe, 0);
        next_cycle();
        rst = 0;
        idle();
        #2;
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_starved", b_starved, 0);

        // A write then A read of 8'h10
        next_cycle();
        a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 16'h1234;
        #2;
        check("wr_a_gnt", a_gnt, 1);
        check("wr_b_gnt", b_gnt, 0);
        check("wr_dwe", mem_dwe, 1);
        check("wr_addr", mem_addr, 8'h10);
        check("wr_wdata", mem_wdata, 16'h1234);
        next_cycle();
        a_we = 0;
        #2;
        check("rd_a_gnt", a_gnt, 1);
        check("rd_dwe", mem_dwe, 0);
        check("wr_no_rvalid", a_rvalid, 0);
        next_cycle();
        idle();
        #2;
        check("rd_a_rvalid", a_rvalid, 1);
        check("rd_rdata", rdata, 16'h1234);
        check("rd_b_gnt", b_gnt, 0);

        // preload 8'h01 and 8'h02
        next_cycle();
        a_req = 1; a_we = 1; a_addr = 8'h01; a_wdata = 16'h0A01;
        next_cycle();
        a_addr = 8'h02; a_wdata = 16'h0B02;

        // continuous contention: A,B,A,B,A,B
        prev_a = 0; prev_b = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            a_req = 1; a_we = 0; a_addr = 8'h01;
            b_req = 1; b_we = 0; b_addr = 8'h02;
            #2;
            check($sformatf("alt_a_gnt%0d", i), a_gnt, (i % 2 == 0));
            check($sformatf("alt_b_gnt%0d", i), b_gnt, (i % 2 == 1));
            if (i > 0) begin
                check($sformatf("alt_a_rv%0d", i), a_rvalid, prev_a);
                check($sformatf("alt_b_rv%0d", i), b_rvalid, prev_b);
                check($sformatf("alt_rdata%0d", i), rdata, prev_a ? 16'h0A01 : 16'h0B02);
            end
            prev_a = (i % 2 == 0);
            prev_b = (i % 2 == 1);
        end
        next_cycle();
        idle();
        #2;
        check("alt_last_b_rv", b_rvalid, 1);
        check("alt_last_rdata", rdata, 16'h0B02);
        check("alt_starved_mw2", b_starved, 0);
        check("alt_starved_mw1", s_b_starved, 1);

        // contention: A read 8'h03 wins, then B write BEEF to 8'hFF, then A reads 8'hFF
        next_cycle();
        a_req = 1; a_we = 0; a_addr = 8'h03;
        b_req = 1; b_we = 1; b_addr = 8'hFF; b_wdata = 16'hBEEF;
        #2;
        check("st_a_gnt", a_gnt, 1);
        check("st_b_gnt", b_gnt, 0);
        next_cycle();
        a_req = 0;
        #2;
        check("st_b_gnt2", b_gnt, 1);
        check("st_b_dwe", mem_dwe, 1);
        check("st_b_addr", mem_addr, 8'hFF);
        check("st_b_wdata", mem_wdata, 16'hBEEF);
        check("st_a_rvalid", a_rvalid, 1);
        next_cycle();
        b_req = 0; b_we = 0;
        a_req = 1; a_we = 0; a_addr = 8'hFF;
        #2;
        check("raw_a_gnt", a_gnt, 1);
        check("st_wait_cnt", dut.wait_cnt, 0);
        check("st_no_b_rv", b_rvalid, 0);
        next_cycle();
        idle();
        #2;
        check("raw_a_rvalid", a_rvalid, 1);
        check("raw_rdata", rdata, 16'hBEEF);

        // read granted, then reset; a read requested during reset is refused
        next_cycle();
        a_req = 1; a_we = 0; a_addr = 8'h10;
        #2;
        check("rr_a_gnt", a_gnt, 1);
        next_cycle();
        rst = 1;
        #2;
        check("rr_gnt_in_rst", a_gnt, 0);
        next_cycle();
        rst = 0;
        idle();
        #2;
        check("rr_a_rvalid", a_rvalid, 0);
        check("rr_b_starved", b_starved, 0);
        check("rr_s_starved", s_b_starved, 0);
        next_cycle();
        a_req = 1; a_addr = 8'h01;
        b_req = 1; b_addr = 8'h02;
        #2;
        check("rr_first_a", a_gnt, 1);
        check("rr_first_b", b_gnt, 0);

        // idle
        next_cycle();
        idle();
        next_cycle();
        #2;
        check("idle_dwe", mem_dwe, 0);
        check("idle_addr", mem_addr, 0);
        check("idle_gnt", {a_gnt, b_gnt}, 0);
        check("idle_rvalid", {a_rvalid, b_rvalid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
